// File: rtl/segment_registrador_pkg.sv
// Shared types and elaboration helpers for the segmented register.
package segment_registrador_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  // Segment index width; a single bit is kept even when SEGS would need fewer.
  function automatic int calc_iw(input int segs);
    int v;
    v = $clog2(segs);
    return (v < 1) ? 1 : v;
  endfunction

  // Segment width; 0 flags an illegal N/SEGS pair so the top can refuse to elaborate.
  function automatic int calc_w(input int n, input int segs);
    if (segs < 1) return 0;
    if ((n % segs) != 0) return 0;
    return n / segs;
  endfunction

  function automatic logic cfg_ok(input int n, input int segs);
    return (segs >= 2) && (calc_w(n, segs) > 0);
  endfunction

endpackage

// File: rtl/segment_registrador_contador_seg.sv
// Modulo-SEGS up-counter with synchronous zero, count enable and terminal-count flag.
// Wraps to 0 when enabled at SEGS-1; zero has priority over enable.
module contador_seg #(
  parameter int SEGS = 4,
  parameter int IW   = 2
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          zero,
  input  logic          en,
  output logic [IW-1:0] cnt,
  output logic          tc
);

  localparam logic [IW-1:0] LAST = IW'(SEGS - 1);

  logic [IW-1:0] r_cnt;
  logic [IW-1:0] w_cnt_next;
  logic          w_tc;

  assign w_tc = (r_cnt == LAST);

  always_comb begin
    w_cnt_next = r_cnt;
    if (zero) begin
      w_cnt_next = '0;
    end else if (en) begin
      w_cnt_next = w_tc ? '0 : (r_cnt + IW'(1));
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign cnt = r_cnt;
  assign tc  = w_tc;

endmodule

// File: rtl/segment_registrador_n.sv
// N-bit register in SEGS segments: parallel load, addressed segment write and FSM-driven
// sequential fill. Optional registered even parity of Q when PARITY_EN is defined.
module segment_registrador_n
  import segment_registrador_pkg::*;
#(
  parameter  int N    = 16,
  parameter  int SEGS = 4,
  localparam int IW   = calc_iw(SEGS),
  localparam int W    = calc_w(N, SEGS)
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          load,
  input  logic [N-1:0]  D,
  input  logic          load_seg,
  input  logic [IW-1:0] sel_seg,
  input  logic [W-1:0]  D_seg,
  input  logic          start,
  input  logic          valid,
  output logic [N-1:0]  Q,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] seg_idx,
  output logic          parity
);

  if (!cfg_ok(N, SEGS)) begin : g_bad_cfg
    $error("segment_registrador_n: N must be a multiple of SEGS and SEGS >= 2");
  end

  state_t        r_state;
  state_t        w_state_next;
  logic [N-1:0]  r_q;
  logic [N-1:0]  w_q_next;
  logic          r_done;
  logic          w_last;
  logic          w_zero;
  logic          w_beat;
  logic          w_tc;
  logic [IW-1:0] w_idx;
  logic          w_seg_we;
  logic [IW-1:0] w_seg_sel;
  logic          w_sel_ok;

  contador_seg #(
    .SEGS(SEGS),
    .IW  (IW)
  ) u_contador (
    .clock(clock),
    .clear(clear),
    .zero (w_zero),
    .en   (w_beat),
    .cnt  (w_idx),
    .tc   (w_tc)
  );

  assign w_sel_ok = (int'(sel_seg) < SEGS);

  // Priority: load > start > fill beat (FILL) > addressed write (IDLE).
  always_comb begin
    w_state_next = r_state;
    w_zero       = 1'b0;
    w_beat       = 1'b0;
    w_last       = 1'b0;
    w_seg_we     = 1'b0;
    w_seg_sel    = w_idx;
    w_q_next     = r_q;
    if (load) begin
      w_q_next     = D;
      w_state_next = ST_IDLE;
      w_zero       = 1'b1;
    end else if (start) begin
      w_state_next = ST_FILL;
      w_zero       = 1'b1;
    end else if (r_state == ST_FILL) begin
      if (valid) begin
        w_beat    = 1'b1;
        w_seg_we  = 1'b1;
        w_seg_sel = w_idx;
        if (w_tc) begin
          w_state_next = ST_IDLE;
          w_last       = 1'b1;
        end
      end
    end else if (load_seg && w_sel_ok) begin
      w_seg_we  = 1'b1;
      w_seg_sel = sel_seg;
    end
    for (int k = 0; k < SEGS; k++) begin
      if (w_seg_we && (int'(w_seg_sel) == k)) begin
        w_q_next[k*W +: W] = D_seg;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_done  <= w_last;
    end
  end

`ifdef PARITY_EN
  logic r_parity;

  // Parity is taken from the next Q so it lands on the same edge as the data.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= ^w_q_next;
    end
  end

  assign parity = r_parity;
`else
  assign parity = 1'b0;
`endif

  assign Q       = r_q;
  assign busy    = (r_state == ST_FILL);
  assign done    = r_done;
  assign seg_idx = w_idx;

endmodule

// File: tb/tb_segment_registrador_n.sv
// Directed table-driven bench for segment_registrador_n at N=16, SEGS=4.
module tb_segment_registrador_n;

  typedef struct {
    logic        ld;
    logic [15:0] d;
    logic        ls;
    logic [1:0]  sel;
    logic [3:0]  ds;
    logic        st;
    logic        vl;
    logic [15:0] q;
    logic        busy;
    logic        done;
    logic [1:0]  idx;
  } vec_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        load;
  logic [15:0] D;
  logic        load_seg;
  logic [1:0]  sel_seg;
  logic [3:0]  D_seg;
  logic        start;
  logic        valid;
  logic [15:0] Q;
  logic        busy;
  logic        done;
  logic [1:0]  seg_idx;
  logic        parity;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  segment_registrador_n #(.N(16), .SEGS(4)) dut (
    .clock   (clock),
    .clear   (clear),
    .load    (load),
    .D       (D),
    .load_seg(load_seg),
    .sel_seg (sel_seg),
    .D_seg   (D_seg),
    .start   (start),
    .valid   (valid),
    .Q       (Q),
    .busy    (busy),
    .done    (done),
    .seg_idx (seg_idx),
    .parity  (parity)
  );

  always #5 clock = ~clock;

  function automatic logic exp_par(input logic [15:0] q);
`ifdef PARITY_EN
    return ^q;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d got=%0h expected=%0h", name, row, act, exp);
    end
  endtask

  task automatic chk_all(input int row, input logic [15:0] q, input logic b, input logic dn, input logic [1:0] ix);
    chk("Q", row, 32'(Q), 32'(q));
    chk("busy", row, 32'(busy), 32'(b));
    chk("done", row, 32'(done), 32'(dn));
    chk("seg_idx", row, 32'(seg_idx), 32'(ix));
    chk("parity", row, 32'(parity), 32'(exp_par(q)));
  endtask

  task automatic idle_inputs();
    load = 0; D = '0; load_seg = 0; sel_seg = '0; D_seg = '0; start = 0; valid = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic void add(input logic ld, input logic [15:0] d, input logic ls, input logic [1:0] sel,
                              input logic [3:0] ds, input logic st, input logic vl,
                              input logic [15:0] q, input logic b, input logic dn, input logic [1:0] ix);
    vec_t v;
    v.ld = ld; v.d = d; v.ls = ls; v.sel = sel; v.ds = ds; v.st = st; v.vl = vl;
    v.q = q; v.busy = b; v.done = dn; v.idx = ix;
    tbl.push_back(v);
  endfunction

  initial begin
    //   ld  D         ls sel ds   st vl   Q         busy done idx
    add(1, 16'hAAAA, 0, 0, 4'h0, 0, 0, 16'hAAAA, 0, 0, 0);
    add(0, 16'h0000, 1, 2, 4'h5, 0, 0, 16'hA5AA, 0, 0, 0);
    add(0, 16'h0000, 1, 0, 4'h3, 0, 0, 16'hA5A3, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 4'h0, 0, 1, 16'hA5A3, 0, 0, 0); // valid in IDLE ignored
    add(0, 16'h0000, 0, 0, 4'h0, 1, 0, 16'hA5A3, 1, 0, 0);
    add(0, 16'h0000, 1, 1, 4'h0, 0, 0, 16'hA5A3, 1, 0, 0); // load_seg while busy
    add(0, 16'h0000, 0, 0, 4'h1, 0, 1, 16'hA5A1, 1, 0, 1);
    add(0, 16'h0000, 0, 0, 4'h2, 0, 1, 16'hA521, 1, 0, 2);
    add(0, 16'h0000, 0, 0, 4'h0, 0, 0, 16'hA521, 1, 0, 2);
    add(0, 16'h0000, 0, 0, 4'h3, 0, 1, 16'hA321, 1, 0, 3);
    add(0, 16'h0000, 0, 0, 4'h4, 0, 1, 16'h4321, 0, 1, 0);
    add(0, 16'h0000, 0, 0, 4'h8, 0, 1, 16'h4321, 0, 0, 0); // no wrap without start
    add(0, 16'h0000, 0, 0, 4'h0, 1, 0, 16'h4321, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 4'hF, 0, 1, 16'h432F, 1, 0, 1);
    add(0, 16'h0000, 0, 0, 4'hF, 0, 1, 16'h43FF, 1, 0, 2);
    add(1, 16'h1234, 0, 0, 4'hF, 0, 1, 16'h1234, 0, 0, 0); // abort by load
    add(0, 16'h0000, 0, 0, 4'hF, 0, 1, 16'h1234, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 4'h0, 1, 0, 16'h1234, 1, 0, 0);
    add(0, 16'h0000, 0, 0, 4'h7, 0, 1, 16'h1237, 1, 0, 1);
    add(0, 16'h0000, 0, 0, 4'h7, 0, 1, 16'h1277, 1, 0, 2);
    add(0, 16'h0000, 0, 0, 4'h7, 0, 1, 16'h1777, 1, 0, 3);
    add(0, 16'h0000, 0, 0, 4'h9, 1, 1, 16'h1777, 1, 0, 0); // restart, valid dropped
    add(0, 16'h0000, 0, 0, 4'h9, 0, 1, 16'h1779, 1, 0, 1);
    add(0, 16'h0000, 0, 0, 4'h9, 0, 1, 16'h1799, 1, 0, 2);
    add(0, 16'h0000, 0, 0, 4'h9, 0, 1, 16'h1999, 1, 0, 3);
    add(0, 16'h0000, 0, 0, 4'h9, 0, 1, 16'h9999, 0, 1, 0);
    add(0, 16'h0000, 0, 0, 4'h0, 1, 0, 16'h9999, 1, 0, 0); // start right after done
    add(1, 16'h0001, 0, 0, 4'h0, 0, 0, 16'h0001, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 4'h5, 1, 1, 16'h0001, 1, 0, 0); // start+valid in IDLE
    add(1, 16'h0003, 0, 0, 4'h0, 0, 0, 16'h0003, 0, 0, 0);
    add(1, 16'h00F0, 0, 0, 4'h0, 1, 0, 16'h00F0, 0, 0, 0); // load beats start
    add(0, 16'h0000, 1, 3, 4'hC, 0, 0, 16'hC0F0, 0, 0, 0);

    idle_inputs();
    clear = 1'b1;
    #3;
    chk_all(-1, 16'h0000, 0, 0, 0);
    clear = 1'b0;

    // Mid-fill asynchronous clear between edges.
    load = 1; D = 16'hFFFF;
    step();
    chk_all(-2, 16'hFFFF, 0, 0, 0);
    idle_inputs(); start = 1;
    step();
    idle_inputs(); valid = 1; D_seg = 4'h1;
    step();
    chk_all(-3, 16'hFFF1, 1, 0, 1);
    idle_inputs();
    #2 clear = 1'b1;
    #1 chk_all(-4, 16'h0000, 0, 0, 0);
    #1 clear = 1'b0;

    foreach (tbl[i]) begin
      load = tbl[i].ld; D = tbl[i].d; load_seg = tbl[i].ls; sel_seg = tbl[i].sel;
      D_seg = tbl[i].ds; start = tbl[i].st; valid = tbl[i].vl;
      step();
      chk_all(i, tbl[i].q, tbl[i].busy, tbl[i].done, tbl[i].idx);
    end
    idle_inputs();
    step();
    chk_all(tbl.size(), 16'hC0F0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/segment_registrador_n.md
# segment_registrador_n

N-bit register split into SEGS equal segments, the parametrised successor of the half-word loading register. It supports three ways of writing the register: a full parallel load, a random write to one addressed segment, and a sequential fill that takes one segment per valid beat, lowest segment first. The sequential fill is controlled by a small FSM that reports busy and done. The block sits between narrow data sources (serial/byte links, keypad or sensor front-ends) and wide datapath registers.

## Interface
- N, default 16: total register width; must be a multiple of SEGS.
- SEGS, default 4: number of segments, ≥ 2; W = N/SEGS bits per segment.
- IW (localparam): max(1, clog2(SEGS)), the width of the segment index.
- clock  in  1  single clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- load  in  1  full parallel load of D.
- D  in  N  full-width data.
- load_seg  in  1  write D_seg into segment sel_seg.
- sel_seg  in  IW  target segment for load_seg.
- D_seg  in  W  segment data, shared by load_seg and the sequential fill.
- start  in  1  begin a sequential fill at segment 0.
- valid  in  1  fill beat: D_seg is written to the current fill segment.
- Q  out  N  register contents.
- busy  out  1  high while the FSM is in FILL.
- done  out  1  one-cycle pulse when the last segment is written.
- seg_idx  out  IW  next segment the fill will write.
- parity  out  1  even parity of Q (see Configuration).

## Operation
- Segment k occupies Q[(k+1)*W-1 : k*W].
- Every write leaves the bits outside the written segment unchanged.
- Reset (clear=1): Q=0, FSM=IDLE, seg_idx=0, busy=0, done=0, parity=0, immediately and independently of clock.
- FSM states:
  - IDLE → FILL on start: seg_idx←0.
  - FILL: valid writes D_seg into segment seg_idx, then seg_idx+1.
  - FILL → IDLE on valid with seg_idx=SEGS-1: seg_idx←0 and done pulses.
- Priority per edge: load > start > valid (FILL only) > load_seg (IDLE only).
- load in any state: Q←D. In FILL it also aborts the fill: FSM←IDLE, seg_idx←0, no done.
- start in FILL: restarts at segment 0. A valid in the same cycle is ignored. Segments already written keep their new values.
- valid in IDLE is ignored.
- load_seg is ignored while busy.
- load_seg with sel_seg ≥ SEGS (non-power-of-two SEGS) is ignored.
- start and valid together in IDLE: enter FILL; that valid is not consumed.
- done is 0 in every cycle other than the completion cycle. No wrap into a second fill without a new start.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- load and load_seg: Q reflects the new data after 1 edge.
- Sequential fill: minimum SEGS+1 edges from the start edge to Q complete (start, then SEGS valid beats). Gaps between valid beats are allowed with no limit.
- done and busy=0 appear on the same edge that writes the last segment.
- A new start is accepted the cycle after done.
- clear asserted mid-fill: all state returns to reset values. Partial data is discarded.

## Configuration
- PARITY_EN defined: parity is a register updated alongside Q, equal to the XOR of the next Q. It has no added latency relative to Q.
- PARITY_EN undefined: the parity port remains and is tied to 0; no parity logic is generated.

## Structure
- Package segment_registrador_pkg holds:
  - the FSM state encoding (IDLE=0, FILL=1);
  - a function computing IW from SEGS;
  - a function computing W and checking N % SEGS == 0 (elaboration error otherwise).
- Sub-module contador_seg: modulo-SEGS up-counter with sync zero, enable and terminal-count output. It drives seg_idx and the FSM's last-segment condition.

## Test plan
- Async clear: with Q=16'hFFFF, pulse clear between edges. Q=0, busy=0, done=0, seg_idx=0 immediately.
- Sequential fill, N=16, SEGS=4: start, then valid with D_seg=4'h1,2,3,4 (with one idle cycle between beats 2 and 3). Q=16'h4321. done is high for exactly one cycle on the 4th beat's edge. busy is high from the start edge until that edge.
- Random segment write: Q=16'hAAAA, load_seg with sel_seg=2, D_seg=4'h5. Q=16'hA5AA. The same operation while busy leaves Q unchanged.
- Abort by load: fill 2 segments with 4'hF, then load with D=16'h1234. Q=16'h1234, busy=0, no done pulse. A later valid has no effect.
- Restart: fill 3 segments with 4'h7, start with valid in the same cycle, then 4 beats of 4'h9. Q=16'h9999. Exactly one done pulse.
- Parity: with PARITY_EN, load 16'h0001 → parity=1; load 16'h0003 → parity=0. Without PARITY_EN, parity stays 0 throughout.
